// File: rtl/cpu4_seq.sv
// Multi-cycle fetch/decode/execute sequencer for the 4-bit CPU: fetches 12-bit
// instructions, holds a 4x4-bit register file and drives the downstream ALU.
module cpu4_seq #(
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [11:0]       imem_data,
    output logic [3:0]        alu_a,
    output logic [3:0]        alu_b,
    output logic [2:0]        alu_op,
    input  logic [3:0]        alu_result,
    output logic              busy,
    output logic              halted,
    output logic              zero,
    input  logic [1:0]        dbg_rsel,
    output logic [3:0]        dbg_rdata
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FETCH  = 2'd1,
        ST_DECODE = 2'd2,
        ST_EXEC   = 2'd3
    } state_t;

    localparam logic [2:0] OP_CTRL   = 3'b111;
    localparam logic [2:0] OP_PASS_A = 3'b110;
    localparam logic [1:0] SUB_HALT  = 2'b00;
    localparam logic [1:0] SUB_LDI   = 2'b01;
    localparam logic [1:0] SUB_JMP   = 2'b10;
    localparam logic [1:0] SUB_JZ    = 2'b11;

    function automatic logic [2:0] f_op(input logic [11:0] w);
        return w[11:9];
    endfunction

    function automatic logic [1:0] f_rd(input logic [11:0] w);
        return w[8:7];
    endfunction

    function automatic logic [1:0] f_rs(input logic [11:0] w);
        return w[6:5];
    endfunction

    function automatic logic [3:0] f_imm(input logic [11:0] w);
        return w[3:0];
    endfunction

    function automatic logic [ADDR_W-1:0] f_target(input logic [11:0] w);
        return ADDR_W'(w[3:0]);
    endfunction

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [11:0]         ir_q, ir_d;
    logic [3:0]          rf_q [0:3];
    logic [3:0]          rf_d [0:3];
    logic [3:0]          alu_a_q, alu_a_d;
    logic [3:0]          alu_b_q, alu_b_d;
    logic [2:0]          alu_op_q, alu_op_d;
    logic                halted_q, halted_d;
    logic                zero_q, zero_d;
    logic                imem_req_q, imem_req_d;
    logic                busy_q, busy_d;

    logic [2:0]          ir_op_s;
    logic [1:0]          ir_rd_s;
    logic [1:0]          ir_rs_s;
    logic [3:0]          ir_imm_s;
    logic [ADDR_W-1:0]   ir_target_s;
    logic [ADDR_W-1:0]   pc_inc_s;
    logic                unused_bits_s;

    assign ir_op_s     = f_op(ir_q);
    assign ir_rd_s     = f_rd(ir_q);
    assign ir_rs_s     = f_rs(ir_q);
    assign ir_imm_s    = f_imm(ir_q);
    assign ir_target_s = f_target(ir_q);
    assign pc_inc_s    = pc_q + ADDR_W'(1);
    // Instruction bit 4 carries no meaning in any format.
    assign unused_bits_s = ir_q[4];

    // Next-state, register-file and ALU-operand computation for every state.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        rf_d     = rf_q;
        alu_a_d  = alu_a_q;
        alu_b_d  = alu_b_q;
        alu_op_d = alu_op_q;
        halted_d = halted_q;
        zero_d   = zero_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d  = ST_FETCH;
                    halted_d = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_FETCH: begin
                if (imem_ack) begin
                    ir_d    = imem_data;
                    state_d = ST_DECODE;
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_DECODE: begin
                if (ir_op_s != OP_CTRL) begin
                    alu_a_d  = rf_q[ir_rd_s];
                    alu_b_d  = rf_q[ir_rs_s];
                    alu_op_d = ir_op_s;
                    state_d  = ST_EXEC;
                end else begin
                    state_d = ST_FETCH;
                    case (ir_rd_s)
                        SUB_HALT: begin
                            pc_d     = pc_inc_s;
                            halted_d = 1'b1;
                            state_d  = ST_IDLE;
                        end
                        SUB_LDI: begin
                            rf_d[ir_rs_s] = ir_imm_s;
                            pc_d          = pc_inc_s;
                        end
                        SUB_JMP: begin
                            pc_d = ir_target_s;
                        end
                        SUB_JZ: begin
                            if (zero_q) begin
                                pc_d = ir_target_s;
                            end else begin
                                pc_d = pc_inc_s;
                            end
                        end
                        default: begin
                            pc_d = pc_inc_s;
                        end
                    endcase
                end
            end
            ST_EXEC: begin
                rf_d[ir_rd_s] = alu_result;
                zero_d        = (alu_result == 4'd0);
                pc_d          = pc_inc_s;
                state_d       = ST_FETCH;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign imem_req_d = (state_d == ST_FETCH);
    assign busy_d     = (state_d != ST_IDLE);

    // State and datapath registers; reset clears everything at once, even mid-fetch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            pc_q       <= {ADDR_W{1'b0}};
            ir_q       <= 12'h000;
            for (int i = 0; i < 4; i++) begin
                rf_q[i] <= 4'd0;
            end
            alu_a_q    <= 4'd0;
            alu_b_q    <= 4'd0;
            alu_op_q   <= OP_PASS_A;
            halted_q   <= 1'b0;
            zero_q     <= 1'b0;
            imem_req_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            ir_q       <= ir_d;
            rf_q       <= rf_d;
            alu_a_q    <= alu_a_d;
            alu_b_q    <= alu_b_d;
            alu_op_q   <= alu_op_d;
            halted_q   <= halted_d;
            zero_q     <= zero_d;
            imem_req_q <= imem_req_d;
            busy_q     <= busy_d;
        end
    end

    assign imem_req  = imem_req_q;
    assign imem_addr = pc_q;
    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_op    = alu_op_q;
    assign busy      = busy_q;
    assign halted    = halted_q;
    assign zero      = zero_q;
    assign dbg_rdata = rf_q[dbg_rsel];

endmodule

// File: tb/tb_cpu4_seq.sv
// Bench for cpu4_seq: an instruction-level model predicts architectural state
// and per-instruction latency; directed programs pin the model with literals.
`timescale 1ns/1ps
module tb_cpu4_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        imem_req;
    logic [3:0]  imem_addr;
    logic        imem_ack;
    logic [11:0] imem_data;
    logic [3:0]  alu_a;
    logic [3:0]  alu_b;
    logic [2:0]  alu_op;
    logic [3:0]  alu_result;
    logic        busy;
    logic        halted;
    logic        zero;
    logic [1:0]  dbg_rsel;
    logic [3:0]  dbg_rdata;

    int total = 0;
    int bad   = 0;

    logic [11:0] mem [16];
    int          ack_delay = 0;
    int          ack_wait  = 0;
    logic        stray_ack = 1'b0;

    // instruction-level model state
    logic [3:0] m_pc;
    logic [3:0] m_rf [4];
    logic       m_zero;
    logic       m_halted;
    logic       m_running;
    logic [3:0] e_a;
    logic [3:0] e_b;
    logic [2:0] e_op;
    int         gap_cnt  = -1;
    int         exp_gap  = 0;
    logic       exp_alu  = 1'b0;
    logic       exp_halt = 1'b0;

    always #5 clk = ~clk;

    cpu4_seq #(.ADDR_W(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_data  (imem_data),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_op     (alu_op),
        .alu_result (alu_result),
        .busy       (busy),
        .halted     (halted),
        .zero       (zero),
        .dbg_rsel   (dbg_rsel),
        .dbg_rdata  (dbg_rdata)
    );

    // ALU stand-in: 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 not A, 110 pass A
    function automatic logic [3:0] alu_fn(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
        case (op)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd4:    return a ^ b;
            3'd5:    return ~a;
            3'd6:    return a;
            default: return b;
        endcase
    endfunction

    assign alu_result = alu_fn(alu_op, alu_a, alu_b);

    function automatic logic [11:0] enc_alu(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] rs);
        return {op, rd, rs, 5'b00000};
    endfunction
    function automatic logic [11:0] enc_ldi(input logic [1:0] rd, input logic [3:0] v);
        return {3'b111, 2'b01, rd, 1'b0, v};
    endfunction
    function automatic logic [11:0] enc_halt();
        return {3'b111, 2'b00, 2'b00, 1'b0, 4'h0};
    endfunction
    function automatic logic [11:0] enc_jmp(input logic [3:0] a);
        return {3'b111, 2'b10, 2'b00, 1'b0, a};
    endfunction
    function automatic logic [11:0] enc_jz(input logic [3:0] a);
        return {3'b111, 2'b11, 2'b00, 1'b0, a};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc = 4'd0;
        for (int i = 0; i < 4; i++) m_rf[i] = 4'd0;
        m_zero = 1'b0; m_halted = 1'b0; m_running = 1'b0;
        e_a = 4'd0; e_b = 4'd0; e_op = 3'b110;
        gap_cnt = -1; exp_alu = 1'b0; exp_halt = 1'b0; exp_gap = 0;
    endtask

    task automatic model_exec();
        logic [11:0] w;
        logic [3:0]  r;
        w = mem[m_pc];
        exp_alu = 1'b0; exp_halt = 1'b0; exp_gap = 2;
        if (w[11:9] != 3'b111) begin
            e_a = m_rf[w[8:7]]; e_b = m_rf[w[6:5]]; e_op = w[11:9];
            r = alu_fn(e_op, e_a, e_b);
            m_rf[w[8:7]] = r;
            m_zero = (r == 4'd0);
            m_pc = m_pc + 4'd1;
            exp_alu = 1'b1; exp_gap = 3;
        end else begin
            case (w[8:7])
                2'b00: begin m_halted = 1'b1; exp_halt = 1'b1; m_pc = m_pc + 4'd1; end
                2'b01: begin m_rf[w[6:5]] = w[3:0]; m_pc = m_pc + 4'd1; end
                2'b10: m_pc = w[3:0];
                default: m_pc = m_zero ? w[3:0] : m_pc + 4'd1;
            endcase
        end
        gap_cnt = 0;
    endtask

    // instruction memory responder with programmable wait states
    initial begin
        imem_ack = 1'b0; imem_data = 12'h000;
        forever begin
            @(posedge clk); #1;
            if (imem_req === 1'b1) begin
                if (ack_wait >= ack_delay) begin
                    imem_ack = 1'b1; imem_data = mem[imem_addr]; ack_wait = 0;
                end else begin
                    imem_ack = 1'b0; ack_wait++;
                end
            end else begin
                imem_ack = stray_ack; imem_data = enc_ldi(2'd3, 4'hA); ack_wait = 0;
            end
        end
    end

    // compare process: DUT against the model on every falling edge
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n !== 1'b1) begin
                chk("rst_req", imem_req, 0);
                chk("rst_busy", busy, 0);
                chk("rst_halted", halted, 0);
                chk("rst_zero", zero, 0);
                chk("rst_alu_a", alu_a, 0);
                chk("rst_alu_b", alu_b, 0);
                chk("rst_alu_op", alu_op, 3'b110);
                chk("rst_pc", imem_addr, 0);
                model_reset();
            end else begin
                if (gap_cnt >= 0) begin
                    gap_cnt++;
                    if (exp_alu && gap_cnt == 2) begin
                        chk("exec_alu_a", alu_a, e_a);
                        chk("exec_alu_b", alu_b, e_b);
                        chk("exec_alu_op", alu_op, e_op);
                    end
                    if (gap_cnt == exp_gap) begin
                        if (exp_halt) begin
                            chk("halt_to_idle", busy, 0);
                            m_running = 1'b0;
                        end else begin
                            chk("next_fetch", imem_req, 1);
                        end
                        gap_cnt = -1;
                    end else begin
                        chk("no_early_fetch", imem_req, 0);
                        chk("busy_in_instr", busy, 1);
                    end
                end
                if (gap_cnt < 0) begin
                    chk("busy", busy, m_running);
                    chk("req", imem_req, m_running);
                    chk("pc", imem_addr, m_pc);
                    chk("zero", zero, m_zero);
                    chk("halted", halted, m_halted);
                    chk("alu_a_hold", alu_a, e_a);
                    chk("alu_b_hold", alu_b, e_b);
                    chk("alu_op_hold", alu_op, e_op);
                    chk("dbg", dbg_rdata, m_rf[dbg_rsel]);
                    if (m_running && imem_ack === 1'b1) begin
                        model_exec();
                    end else if (!m_running && start === 1'b1) begin
                        m_running = 1'b1;
                        m_halted  = 1'b0;
                    end
                end
            end
        end
    end

    task automatic check_reg(input string nm, input logic [1:0] idx, input logic [3:0] exp);
        @(negedge clk); #1 dbg_rsel = idx;
        #1 chk(nm, dbg_rdata, exp);
    endtask

    task automatic do_reset();
        @(negedge clk); #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 16; i++) mem[i] = 12'h000;
    endtask

    task automatic load_prog1();
        clear_mem();
        mem[0] = enc_ldi(2'd1, 4'd5);
        mem[1] = enc_ldi(2'd2, 4'd3);
        mem[2] = enc_alu(3'b000, 2'd1, 2'd2);
        mem[3] = enc_halt();
    endtask

    task automatic load_prog2(input logic [3:0] r2v);
        clear_mem();
        mem[0] = enc_ldi(2'd1, 4'd7);
        mem[1] = enc_ldi(2'd2, r2v);
        mem[2] = enc_alu(3'b001, 2'd1, 2'd2);
        mem[3] = enc_jz(4'd9);
        mem[4] = enc_halt();
        mem[9] = enc_halt();
    endtask

    // pulse start, then count busy cycles until idle (bounded)
    task automatic run_prog(input int poke, output int ncyc, output logic first_halted);
        logic done;
        int   guard;
        ncyc = 0; done = 1'b0; guard = 0; first_halted = 1'b1;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        while (!done) begin
            @(negedge clk);
            guard++;
            if (busy === 1'b1) begin
                ncyc++;
                if (ncyc == 1) first_halted = halted;
            end else begin
                done = 1'b1;
            end
            if (!done && guard > 300) begin
                total++; bad++;
                $display("FAIL run_timeout: still busy after %0d cycles, want idle", guard);
                done = 1'b1;
            end
            if (!done) begin
                @(posedge clk); #1;
                dbg_rsel = dbg_rsel + 2'd1;
                start = (ncyc == poke);
            end
        end
        start = 1'b0;
    endtask

    initial begin
        int   n;
        logic fh;
        rst_n = 1'b0; start = 1'b0; dbg_rsel = 2'd0;
        clear_mem();
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   n;
        logic fh;
        rst_n = 1'b0; start = 1'b0; dbg_rsel = 2'd0;
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b1;
        repeat (4) @(negedge clk);
        #1;
        chk("idle_req", imem_req, 0);
        chk("idle_busy", busy, 0);
        chk("idle_halted", halted, 0);
        chk("idle_alu_op", alu_op, 3'b110);
        chk("idle_pc", imem_addr, 0);
        check_reg("idle_r1", 2'd1, 4'd0);

        // LDI, LDI, ADD, HALT with zero-wait fetches
        load_prog1();
        ack_delay = 0;
        run_prog(-1, n, fh);
        chk("p1_cycles", n, 9);
        chk("p1_first_halted", fh, 0);
        check_reg("p1_r1", 2'd1, 4'd8);
        check_reg("p1_r2", 2'd2, 4'd3);
        chk("p1_zero", zero, 0);
        chk("p1_halted", halted, 1);
        chk("p1_pc", imem_addr, 4);

        // stray ack while idle must be ignored
        stray_ack = 1'b1;
        repeat (3) @(posedge clk);
        #1 stray_ack = 1'b0;
        check_reg("stray_r3", 2'd3, 4'd0);
        chk("stray_pc", imem_addr, 4);
        chk("stray_busy", busy, 0);

        // same program with four wait states on every fetch
        do_reset();
        load_prog1();
        ack_delay = 4;
        run_prog(-1, n, fh);
        chk("p1w_cycles", n, 25);
        check_reg("p1w_r1", 2'd1, 4'd8);
        chk("p1w_pc", imem_addr, 4);
        chk("p1w_halted", halted, 1);
        ack_delay = 0;

        // SUB to zero, JZ taken; start poked mid-run is ignored
        do_reset();
        load_prog2(4'd7);
        run_prog(3, n, fh);
        chk("p2_cycles", n, 11);
        chk("p2_zero", zero, 1);
        chk("p2_pc", imem_addr, 10);
        check_reg("p2_r1", 2'd1, 4'd0);

        // JZ not taken
        do_reset();
        load_prog2(4'd6);
        run_prog(-1, n, fh);
        chk("p3_cycles", n, 11);
        chk("p3_zero", zero, 0);
        chk("p3_pc", imem_addr, 5);
        check_reg("p3_r1", 2'd1, 4'd1);

        // PC wrap 15 -> 0 and restart from the halted PC
        do_reset();
        clear_mem();
        mem[0]  = enc_halt();
        mem[1]  = enc_jmp(4'd15);
        mem[15] = enc_alu(3'b101, 2'd0, 2'd0);
        run_prog(-1, n, fh);
        chk("w1_cycles", n, 2);
        chk("w1_pc", imem_addr, 1);
        chk("w1_halted", halted, 1);
        run_prog(-1, n, fh);
        chk("w2_cycles", n, 7);
        chk("w2_halted_cleared", fh, 0);
        check_reg("w2_r0", 2'd0, 4'hF);
        chk("w2_zero", zero, 0);
        chk("w2_pc", imem_addr, 1);
        run_prog(-1, n, fh);
        chk("w3_cycles", n, 7);
        check_reg("w3_r0", 2'd0, 4'h0);
        chk("w3_zero", zero, 1);
        chk("w3_pc", imem_addr, 1);

        // reset while a fetch is waiting for ack
        do_reset();
        load_prog1();
        ack_delay = 4;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 chk("fw_req_high", imem_req, 1);
        #1 rst_n = 1'b0;
        #1 chk("fw_async_req", imem_req, 0);
        chk("fw_async_busy", busy, 0);
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        check_reg("fw_r1", 2'd1, 4'd0);
        chk("fw_pc", imem_addr, 0);
        ack_delay = 0;

        // reset during EXEC of the ADD: no writeback
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        n = 0;
        while (!(exp_alu && gap_cnt == 1) && n < 50) begin
            @(negedge clk); #1;
            n++;
        end
        chk("ex_reach_decode", (n < 50), 1);
        @(posedge clk);
        #2 chk("ex_alu_a", alu_a, 5);
        chk("ex_alu_b", alu_b, 3);
        chk("ex_alu_op", alu_op, 0);
        chk("ex_req_low", imem_req, 0);
        #1 rst_n = 1'b0;
        #1 chk("ex_async_busy", busy, 0);
        chk("ex_async_alu_op", alu_op, 3'b110);
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        check_reg("ex_r1", 2'd1, 4'd0);
        check_reg("ex_r2", 2'd2, 4'd0);
        chk("ex_zero", zero, 0);
        chk("ex_pc", imem_addr, 0);

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
